pcap_frame_sequencer: RTL and testbench
=======================================

# pcap_frame_sequencer

Control sequencer for the position-capture datapath. It holds a programmable table of capture word indices and runs the arm/disarm state machine. On each qualified capture it walks the table, presenting one index per cycle to the external word mux and forwarding the selected 32-bit word to the DMA-side data port. It also reports health and completion status to the register interface.

## Interface
Parameters:
- MAX_WORDS, 64, depth of the index table (maximum words per frame)
- IDX_BITS, 6, width of one table entry (log2 of the word-mux size)

Ports:
- clk_i  in  1  system clock; all logic on rising edge
- reset_i  in  1  synchronous, active-high reset
- START_WRITE  in  1  strobe: clear table write pointer and word count
- WRITE  in  32  table entry; bits [IDX_BITS-1:0] used, rest ignored
- WRITE_WSTB  in  1  strobe: append WRITE to table
- ARM  in  1  strobe: arm block
- DISARM  in  1  strobe: abort/disarm
- enable_i  in  1  capture enable level
- capture_i  in  1  single-cycle capture pulse (already edge-qualified)
- dma_full_i  in  1  DMA FIFO full
- word_idx_o  out  IDX_BITS  index to external word mux (combinational from read pointer)
- word_i  in  32  mux output for word_idx_o, valid same cycle
- pcap_dat_o  out  32  captured word
- pcap_dat_valid_o  out  1  pcap_dat_o valid strobe
- pcap_actv_o  out  1  block armed/active
- pcap_done_o  out  1  one-cycle pulse on return to IDLE from active
- HEALTH  out  32  0 OK, 1 capture too close, 2 DMA overflow

## Operation
- Table: WRITE_WSTB writes table[wr_ptr], then wr_ptr/count increment. Count saturates at MAX_WORDS; further writes are ignored. START_WRITE sets count=0. START_WRITE and WRITE_WSTB in the same cycle: clear first, then write entry 0, giving count=1. Writes while pcap_actv_o=1 are ignored.
- States: IDLE, ARMED, SEND.
- IDLE: ARM → ARMED, HEALTH←0.
- ARMED:
  - capture_i & enable_i & count>0 → SEND, rd_ptr←0.
  - capture with count=0 is ignored.
  - Falling edge of enable_i (registered previous value 1, now 0) → IDLE.
  - DISARM → IDLE.
- SEND: each cycle, pcap_dat_o←word_i, pcap_dat_valid_o←1, rd_ptr++.
  - After the word at rd_ptr=count-1: → ARMED, or → IDLE if an enable_i falling edge was latched during the frame.
- Abort priority in ARMED/SEND, highest first:
  1. DISARM → IDLE; HEALTH unchanged.
  2. dma_full_i in SEND → IDLE, HEALTH←2.
  3. capture_i in SEND, including the last-word cycle → IDLE, HEALTH←1.
- On abort, the word for the current cycle is not emitted.
- An enable_i fall in SEND does not abort; the frame completes.
- ARM while active is ignored. ARM and DISARM together in IDLE: stay IDLE.
- pcap_done_o pulses on every ARMED/SEND → IDLE transition.
- reset_i: state IDLE, count=0, pointers=0; table contents need not reset.

## Timing
- Reset values: pcap_dat_o=0, pcap_dat_valid_o=0, pcap_actv_o=0, pcap_done_o=0, HEALTH=0, word_idx_o=table[0]; these values are don't-care while IDLE.
- capture_i high in cycle c (ARMED): SEND from c+1; pcap_dat_valid_o high c+2 … c+1+count, consecutively with no gaps.
- pcap_actv_o registered: high the cycle after ARM is sampled, low in the same cycle pcap_done_o is high.
- Abort sampled in cycle a: no valid in cycle a+1; pcap_done_o, pcap_actv_o=0 and the HEALTH update all appear in cycle a+1.
- A capture in the first ARMED cycle after a frame completes is accepted (minimum frame spacing count+1 cycles).
- word_idx_o is valid throughout SEND; the external mux is purely combinational.

## Test plan
- Write table [5,0,37], ARM, enable_i=1, posbus5=0x11, posbus0=0x22, word37=0x33; capture at c → valid at c+2,c+3,c+4 with data 0x11,0x22,0x33; HEALTH=0; actv stays 1.
- Same table, second capture at c+3 (during SEND) → only 0x11,0x22 emitted; HEALTH=1; done pulse at c+4; actv=0 at c+4.
- 4-entry table, dma_full_i asserted at c+2 → one word emitted, HEALTH=2, done pulse at c+3; subsequent ARM clears HEALTH to 0.
- DISARM sampled mid-frame → valid drops next cycle, done pulse, HEALTH=0; capture afterwards produces no data.
- 65 WRITE_WSTB strobes → 64-word frame on capture; then START_WRITE plus one write → 1-word frame; a write while armed → table unchanged.
- enable_i falls two cycles into a 5-word frame → all 5 words emitted, then done pulse, actv=0; ARM before enable_i rises → stays ARMED until capture.

Source files
------------

// File: rtl/pcap_frame_sequencer.sv
// rtl/pcap_frame_sequencer.sv - capture index table, arm/disarm FSM and word streaming to the DMA port
module pcap_frame_sequencer #(
    parameter int MAX_WORDS = 64,
    parameter int IDX_BITS  = 6
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                START_WRITE,
    input  logic [31:0]         WRITE,
    input  logic                WRITE_WSTB,
    input  logic                ARM,
    input  logic                DISARM,
    input  logic                enable_i,
    input  logic                capture_i,
    input  logic                dma_full_i,
    output logic [IDX_BITS-1:0] word_idx_o,
    input  logic [31:0]         word_i,
    output logic [31:0]         pcap_dat_o,
    output logic                pcap_dat_valid_o,
    output logic                pcap_actv_o,
    output logic                pcap_done_o,
    output logic [31:0]         HEALTH
);
    localparam int PTR_BITS = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int CNT_BITS = $clog2(MAX_WORDS + 1);
    localparam logic [CNT_BITS-1:0] MAX_CNT = CNT_BITS'(MAX_WORDS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;

    logic [IDX_BITS-1:0] table_q [MAX_WORDS];
    logic [CNT_BITS-1:0] count_q;
    logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0]          state_q, state_d;
    logic                enable_q, en_fell_q, en_fell_d;
    logic [31:0]         health_d;
    logic                emit;
    logic                tbl_idle, start_eff, wr_en, enable_fall, last_word;
    logic [CNT_BITS-1:0] wr_base;
    logic                unused_write_bits;

    assign unused_write_bits = ^WRITE[31:IDX_BITS];
    assign word_idx_o  = table_q[rd_ptr_q];
    assign pcap_actv_o = (state_q != S_IDLE);

    // Table is frozen while the block is active; a clear in the same cycle as a write lands the write at entry 0.
    assign tbl_idle    = (state_q == S_IDLE);
    assign start_eff   = START_WRITE && tbl_idle;
    assign wr_base     = start_eff ? '0 : count_q;
    assign wr_en       = WRITE_WSTB && tbl_idle && (wr_base < MAX_CNT);
    assign enable_fall = enable_q && !enable_i;
    assign last_word   = (CNT_BITS'(rd_ptr_q) == count_q - 1'b1);

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            table_q[wr_base[PTR_BITS-1:0]] <= WRITE[IDX_BITS-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        health_d  = HEALTH;
        rd_ptr_d  = rd_ptr_q;
        en_fell_d = en_fell_q;
        emit      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ARM && !DISARM) begin
                    state_d  = S_ARMED;
                    health_d = 32'd0;
                end
            end
            S_ARMED: begin
                if (DISARM || enable_fall) begin
                    state_d = S_IDLE;
                end else if (capture_i && enable_i && (count_q != '0)) begin
                    state_d   = S_SEND;
                    rd_ptr_d  = '0;
                    en_fell_d = 1'b0;
                end
            end
            S_SEND: begin
                if (DISARM) begin
                    state_d = S_IDLE;
                end else if (dma_full_i) begin
                    state_d  = S_IDLE;
                    health_d = 32'd2;
                end else if (capture_i) begin
                    state_d  = S_IDLE;
                    health_d = 32'd1;
                end else begin
                    emit = 1'b1;
                    if (enable_fall) begin
                        en_fell_d = 1'b1;
                    end
                    // An enable drop mid-frame only takes effect once the frame is complete.
                    if (last_word) begin
                        state_d = (en_fell_q || enable_fall) ? S_IDLE : S_ARMED;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d != S_SEND) begin
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q          <= S_IDLE;
            count_q          <= '0;
            rd_ptr_q         <= '0;
            enable_q         <= 1'b0;
            en_fell_q        <= 1'b0;
            pcap_dat_o       <= 32'd0;
            pcap_dat_valid_o <= 1'b0;
            pcap_done_o      <= 1'b0;
            HEALTH           <= 32'd0;
        end else begin
            state_q          <= state_d;
            rd_ptr_q         <= rd_ptr_d;
            enable_q         <= enable_i;
            en_fell_q        <= en_fell_d;
            HEALTH           <= health_d;
            pcap_dat_valid_o <= emit;
            pcap_done_o      <= (state_q != S_IDLE) && (state_d == S_IDLE);
            if (emit) begin
                pcap_dat_o <= word_i;
            end
            if (wr_en) begin
                count_q <= wr_base + 1'b1;
            end else if (start_eff) begin
                count_q <= '0;
            end
        end
    end
endmodule

// File: tb/tb_pcap_frame_sequencer.sv
// tb/tb_pcap_frame_sequencer.sv - directed self-checking bench for pcap_frame_sequencer
module tb_pcap_frame_sequencer;
    logic        clk_i = 1'b0;
    logic        reset_i, START_WRITE, WRITE_WSTB, ARM, DISARM;
    logic        enable_i, capture_i, dma_full_i;
    logic [31:0] WRITE, word_i, pcap_dat_o, HEALTH;
    logic [5:0]  word_idx_o;
    logic        pcap_dat_valid_o, pcap_actv_o, pcap_done_o;
    logic [31:0] mux [64];
    int          checks = 0;
    int          errors = 0;

    always #5 clk_i = ~clk_i;
    assign word_i = mux[word_idx_o];

    pcap_frame_sequencer #(.MAX_WORDS(64), .IDX_BITS(6)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .START_WRITE(START_WRITE), .WRITE(WRITE),
        .WRITE_WSTB(WRITE_WSTB), .ARM(ARM), .DISARM(DISARM), .enable_i(enable_i),
        .capture_i(capture_i), .dma_full_i(dma_full_i), .word_idx_o(word_idx_o),
        .word_i(word_i), .pcap_dat_o(pcap_dat_o), .pcap_dat_valid_o(pcap_dat_valid_o),
        .pcap_actv_o(pcap_actv_o), .pcap_done_o(pcap_done_o), .HEALTH(HEALTH)
    );

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic start, input logic [31:0] val);
        START_WRITE = start;
        WRITE_WSTB  = 1'b1;
        WRITE       = val;
        tick;
        START_WRITE = 1'b0;
        WRITE_WSTB  = 1'b0;
    endtask

    task automatic pulse_arm;
        ARM = 1'b1;
        tick;
        ARM = 1'b0;
    endtask

    task automatic pulse_capture;
        capture_i = 1'b1;
        tick;
        capture_i = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1; START_WRITE = 1'b0; WRITE_WSTB = 1'b0; WRITE = 32'd0;
        ARM = 1'b0; DISARM = 1'b0; enable_i = 1'b0; capture_i = 1'b0; dma_full_i = 1'b0;
        for (int i = 0; i < 64; i++) mux[i] = 32'h1000 + 32'(i);
        mux[5] = 32'h11; mux[0] = 32'h22; mux[37] = 32'h33;

        tick; tick;
        chk("rst_valid", {31'd0, pcap_dat_valid_o}, 32'd0);
        chk("rst_actv", {31'd0, pcap_actv_o}, 32'd0);
        chk("rst_done", {31'd0, pcap_done_o}, 32'd0);
        chk("rst_health", HEALTH, 32'd0);
        chk("rst_dat", pcap_dat_o, 32'd0);
        reset_i = 1'b0;
        tick;

        // table [5,0,37], clear and first write in the same cycle
        wr(1'b1, 32'd5); wr(1'b0, 32'd0); wr(1'b0, 32'd37);
        chk("t1_idx0", {26'd0, word_idx_o}, 32'd5);
        pulse_arm;
        chk("t1_actv", {31'd0, pcap_actv_o}, 32'd1);
        chk("t1_health", HEALTH, 32'd0);
        enable_i = 1'b1;
        tick;
        pulse_capture;
        chk("t1_lat", {31'd0, pcap_dat_valid_o}, 32'd0);
        tick; chk("t1_v0", {31'd0, pcap_dat_valid_o}, 32'd1); chk("t1_d0", pcap_dat_o, 32'h11);
        tick; chk("t1_v1", {31'd0, pcap_dat_valid_o}, 32'd1); chk("t1_d1", pcap_dat_o, 32'h22);
        tick; chk("t1_v2", {31'd0, pcap_dat_valid_o}, 32'd1); chk("t1_d2", pcap_dat_o, 32'h33);
        chk("t1_health_end", HEALTH, 32'd0);
        chk("t1_actv_end", {31'd0, pcap_actv_o}, 32'd1);
        chk("t1_done_end", {31'd0, pcap_done_o}, 32'd0);

        // capture in first ARMED cycle accepted, then a second capture mid-frame aborts
        pulse_capture;
        chk("t2_lat", {31'd0, pcap_dat_valid_o}, 32'd0);
        tick; chk("t2_d0", pcap_dat_o, 32'h11); chk("t2_v0", {31'd0, pcap_dat_valid_o}, 32'd1);
        tick; chk("t2_d1", pcap_dat_o, 32'h22);
        pulse_capture;
        chk("t2_abort_valid", {31'd0, pcap_dat_valid_o}, 32'd0);
        chk("t2_done", {31'd0, pcap_done_o}, 32'd1);
        chk("t2_actv", {31'd0, pcap_actv_o}, 32'd0);
        chk("t2_health", HEALTH, 32'd1);
        tick; chk("t2_done_pulse", {31'd0, pcap_done_o}, 32'd0);

        // 4-entry table, DMA overflow after first word
        wr(1'b1, 32'd1); wr(1'b0, 32'd2); wr(1'b0, 32'd3); wr(1'b0, 32'd4);
        pulse_arm;
        chk("t3_arm_clr", HEALTH, 32'd0);
        pulse_capture;
        tick; chk("t3_d0", pcap_dat_o, 32'h1001);
        dma_full_i = 1'b1;
        tick;
        dma_full_i = 1'b0;
        chk("t3_valid", {31'd0, pcap_dat_valid_o}, 32'd0);
        chk("t3_done", {31'd0, pcap_done_o}, 32'd1);
        chk("t3_health", HEALTH, 32'd2);
        chk("t3_actv", {31'd0, pcap_actv_o}, 32'd0);
        pulse_arm;
        chk("t3_rearm_health", HEALTH, 32'd0);
        chk("t3_rearm_actv", {31'd0, pcap_actv_o}, 32'd1);

        // DISARM mid-frame
        pulse_capture;
        tick; chk("t4_d0", pcap_dat_o, 32'h1001);
        DISARM = 1'b1;
        tick;
        DISARM = 1'b0;
        chk("t4_valid", {31'd0, pcap_dat_valid_o}, 32'd0);
        chk("t4_done", {31'd0, pcap_done_o}, 32'd1);
        chk("t4_actv", {31'd0, pcap_actv_o}, 32'd0);
        chk("t4_health", HEALTH, 32'd0);
        pulse_capture;
        tick;
        chk("t4_idle_valid", {31'd0, pcap_dat_valid_o}, 32'd0);
        chk("t4_idle_actv", {31'd0, pcap_actv_o}, 32'd0);

        // 65 writes saturate at 64 entries; upper WRITE bits ignored
        START_WRITE = 1'b1;
        tick;
        START_WRITE = 1'b0;
        for (int i = 0; i < 65; i++) wr(1'b0, (i < 64) ? (32'hFFFF_FFC0 | 32'(i)) : 32'd7);
        chk("t5_idx0", {26'd0, word_idx_o}, 32'd0);
        pulse_arm;
        pulse_capture;
        for (int i = 0; i < 64; i++) begin
            tick;
            chk("t5_valid", {31'd0, pcap_dat_valid_o}, 32'd1);
            chk("t5_data", pcap_dat_o, mux[i]);
        end
        tick;
        chk("t5_len", {31'd0, pcap_dat_valid_o}, 32'd0);
        chk("t5_actv", {31'd0, pcap_actv_o}, 32'd1);
        DISARM = 1'b1;
        tick;
        DISARM = 1'b0;
        wr(1'b1, 32'd9);
        pulse_arm;
        chk("t5_idx9", {26'd0, word_idx_o}, 32'd9);
        wr(1'b1, 32'd21);
        chk("t5_armed_write", {26'd0, word_idx_o}, 32'd9);
        pulse_capture;
        tick;
        chk("t5_one_valid", {31'd0, pcap_dat_valid_o}, 32'd1);
        chk("t5_one_data", pcap_dat_o, 32'h1009);
        tick;
        chk("t5_one_end", {31'd0, pcap_dat_valid_o}, 32'd0);
        chk("t5_one_actv", {31'd0, pcap_actv_o}, 32'd1);

        // enable falls two cycles into a 5-word frame: frame completes, then IDLE
        DISARM = 1'b1;
        tick;
        DISARM = 1'b0;
        wr(1'b1, 32'd10);
        for (int i = 11; i < 15; i++) wr(1'b0, 32'(i));
        pulse_arm;
        pulse_capture;
        tick; chk("t6_d10", pcap_dat_o, 32'h100A);
        enable_i = 1'b0;
        for (int i = 11; i < 14; i++) begin
            tick;
            chk("t6_valid", {31'd0, pcap_dat_valid_o}, 32'd1);
            chk("t6_data", pcap_dat_o, mux[i]);
            chk("t6_no_done", {31'd0, pcap_done_o}, 32'd0);
        end
        tick;
        chk("t6_last", pcap_dat_o, 32'h100E);
        chk("t6_done", {31'd0, pcap_done_o}, 32'd1);
        chk("t6_actv", {31'd0, pcap_actv_o}, 32'd0);
        tick;
        chk("t6_after_valid", {31'd0, pcap_dat_valid_o}, 32'd0);
        chk("t6_after_done", {31'd0, pcap_done_o}, 32'd0);

        // ARM with enable low stays ARMED; capture ignored until enable rises
        pulse_arm;
        chk("t7_actv", {31'd0, pcap_actv_o}, 32'd1);
        pulse_capture;
        tick;
        chk("t7_ign_valid", {31'd0, pcap_dat_valid_o}, 32'd0);
        chk("t7_still_armed", {31'd0, pcap_actv_o}, 32'd1);
        enable_i = 1'b1;
        tick;
        pulse_capture;
        tick;
        chk("t7_valid", {31'd0, pcap_dat_valid_o}, 32'd1);
        chk("t7_data", pcap_dat_o, 32'h100A);
        DISARM = 1'b1;
        tick;
        DISARM = 1'b0;
        chk("t7_disarm", {31'd0, pcap_actv_o}, 32'd0);
        ARM = 1'b1; DISARM = 1'b1;
        tick;
        ARM = 1'b0; DISARM = 1'b0;
        chk("t8_arm_disarm", {31'd0, pcap_actv_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
